// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic-unit arbiter slice.
//   OP_*     : 2-bit opcodes of the bitwise logic unit
//   state_t  : result-slot state (IDLE = slot empty, FULL = slot holds a result)
package logic_unit_pkg;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/logic_unit.sv
// Combinational w-bit bitwise logic unit.
//   or_gate    : word-wide OR gate (a | b), shared building block
//   logic_unit : op (2) selects OR/AND/XOR/NOR of a (w) and b (w), result y (w)
module or_gate #(
    parameter int unsigned w = 16
) (
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    output logic [w-1:0] y
);
    assign y = a | b;
endmodule

module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int unsigned w = 16
) (
    input  logic [1:0]   op,
    input  logic [w-1:0] a,
    input  logic [w-1:0] b,
    output logic [w-1:0] y
);
    logic [w-1:0] or_y;

    or_gate #(.w(w)) u_or (
        .a (a),
        .b (b),
        .y (or_y)
    );

    // NOR is taken as the complement of the shared OR word.
    for (genvar i = 0; i < w; i++) begin : g_bit
        logic bit_y;

        always_comb begin
            bit_y = or_y[i];
            unique case (op)
                OP_OR:   bit_y = or_y[i];
                OP_AND:  bit_y = a[i] & b[i];
                OP_XOR:  bit_y = a[i] ^ b[i];
                OP_NOR:  bit_y = ~or_y[i];
                default: bit_y = or_y[i];
            endcase
        end

        assign y[i] = bit_y;
    end
endmodule

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for one shared bitwise logic unit.
//   clk, rst_b                      : clock (rising edge), async active-low reset
//   reqX_valid/op/a/b, reqX_ready   : request channels X = 0, 1 (valid/ready)
//   res_valid/data/id, res_ready    : single registered result slot, tagged with requester id
//   op_count                        : wrap-around count of consumed results
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int unsigned w     = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req0_valid,
    input  logic [1:0]       req0_op,
    input  logic [w-1:0]     req0_a,
    input  logic [w-1:0]     req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_op,
    input  logic [w-1:0]     req1_a,
    input  logic [w-1:0]     req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [w-1:0]     res_data,
    output logic             res_id,
    input  logic             res_ready,
    output logic [CNT_W-1:0] op_count
);
    state_t           state_q, state_d;
    logic [w-1:0]     res_data_q, res_data_d;
    logic             res_id_q, res_id_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             grant0, grant1;
    logic             can_accept;
    logic             xfer0, xfer1;
    logic             drain;
    logic [1:0]       sel_op;
    logic [w-1:0]     sel_a, sel_b;
    logic [w-1:0]     lu_y;

    assign res_valid = (state_q == FULL);
    assign drain     = res_valid & res_ready;

    // Contention goes to the requester that did not win last time.
    assign grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

    assign can_accept = (state_q == IDLE) | drain;
    assign req0_ready = grant0 & can_accept;
    assign req1_ready = grant1 & can_accept;
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;

    // Operand mux keyed on the grant only, so readiness never depends on data.
    assign sel_op = grant1 ? req1_op : req0_op;
    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;

    logic_unit #(.w(w)) u_logic_unit (
        .op (sel_op),
        .a  (sel_a),
        .b  (sel_b),
        .y  (lu_y)
    );

    always_comb begin
        state_d      = state_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        op_count_d   = op_count_q;

        if (drain) begin
            op_count_d = op_count_q + CNT_W'(1);
        end

        if (xfer0 | xfer1) begin
            state_d      = FULL;
            res_data_d   = lu_y;
            res_id_d     = xfer1;
            last_grant_d = xfer1;
        end else if (drain) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
            op_count_q   <= op_count_d;
        end
    end

    assign res_data = res_data_q;
    assign res_id   = res_id_q;
    assign op_count = op_count_q;
endmodule
